button_event_gen: RTL and testbench
===================================

# button_event_gen

Consumes the per-button debounced levels produced by the I/O debouncer and converts them into single-cycle event pulses for the CPU-facing I/O logic. Events are press, release, long-press and, optionally, auto-repeat. Each channel runs an independent state machine. All channels share one free-running tick prescaler, so hold durations are measured in coarse ticks rather than clock cycles.

## Interface
- `width`, 1, number of independent button channels
- `tick_count_max`, 25000, clock cycles per hold-timing tick; must be ≥1
- `long_press_ticks`, 1000, ticks a button must stay high before a long-press event; must be ≥1
- `repeat_ticks`, 200, ticks between auto-repeat events once long-press has fired; must be ≥1
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `debounced_signal`  in  `width`  debounced button levels, already synchronous to `clk`
- `press_pulse`  out  `width`  one-cycle pulse on a 0→1 input transition
- `release_pulse`  out  `width`  one-cycle pulse on a 1→0 input transition
- `long_press_pulse`  out  `width`  one-cycle pulse when the hold reaches `long_press_ticks`
- `repeat_pulse`  out  `width`  one-cycle pulse every `repeat_ticks` while held past long-press
- `held`  out  `width`  level, high while the channel is in HELD state

## Operation
- **Prescaler**
  - Shared counter runs 0..`tick_count_max`-1, then wraps to 0.
  - `tick` is an internal one-cycle strobe asserted in the cycle the counter equals `tick_count_max`-1.
  - When `tick_count_max`=1, `tick` is asserted every cycle.
  - Counter widths are derived with `log2` of their max value plus one bit, so no counter overflows.
- **Per-channel registers**
  - `prev`: previous sampled input.
  - State: IDLE, PRESSED or HELD.
  - `hold_cnt`: sized for `long_press_ticks`.
  - `rep_cnt`: sized for `repeat_ticks`.
- **Edge detection**
  - rise = `in & ~prev`; fall = `~in & prev`.
  - `prev` <= `in` every cycle.
- **State transitions**
  - IDLE: on rise → PRESSED, `hold_cnt` <= 0, `press_pulse` <= 1.
  - PRESSED, input low: → IDLE, `release_pulse` <= 1.
  - PRESSED, input high and `tick`:
    - If `hold_cnt` == `long_press_ticks`-1 → HELD, `long_press_pulse` <= 1, `rep_cnt` <= 0.
    - Otherwise `hold_cnt` <= `hold_cnt`+1.
  - HELD, input low: → IDLE, `release_pulse` <= 1.
  - HELD, input high and `tick`:
    - If `rep_cnt` == `repeat_ticks`-1 → `repeat_pulse` <= 1, `rep_cnt` <= 0.
    - Otherwise `rep_cnt` <= `rep_cnt`+1.
- **Simultaneous events**
  - Release has priority over tick: when the input falls in the same cycle a threshold would be reached, only `release_pulse` fires.
  - No long-press or repeat pulse is emitted in that case.
- **Pulse width**: all pulse outputs are registered and cleared every cycle they are not set, so each is exactly one cycle wide.

## Timing
- **Reset values**
  - All outputs are 0.
  - Prescaler is 0; all channels are in IDLE with `prev`=0 and counters 0.
- **Reset mid-operation**
  - Any in-flight hold is discarded; no release pulse is emitted for it.
  - If the input is still high after `rst` deasserts, `press_pulse` fires one cycle later, because `prev` was reset to 0.
- **Latency**: input transition at clock edge N → `press_pulse`/`release_pulse` high in cycle N+1 (one cycle).
- **Long-press timing**
  - The tick phase is free-running, so `long_press_pulse` arrives between (`long_press_ticks`-1)·`tick_count_max`+1 and `long_press_ticks`·`tick_count_max` cycles after `press_pulse`.
  - It is one cycle after the qualifying tick.
- **Auto-repeat timing**
  - The first `repeat_pulse` comes exactly `repeat_ticks`·`tick_count_max` cycles after `long_press_pulse`.
  - Later repeat pulses follow at the same period.
- **Bounded pulse rate**: a single press cannot produce two press pulses. Every press pulse is paired with exactly one release pulse, unless reset intervenes.

## Configuration
- **`BUTTON_REPEAT_EN` defined**: auto-repeat behaves as described above.
- **`BUTTON_REPEAT_EN` undefined**
  - `rep_cnt` is not built and `repeat_pulse` is tied to 0.
  - HELD only waits for release.
  - Press, release, long-press and `held` timing are unchanged.

## Test plan
Bench parameters: `width`=2, `tick_count_max`=4, `long_press_ticks`=3, `repeat_ticks`=2, with `BUTTON_REPEAT_EN` defined unless stated.
- **Short press**: ch0 high for 5 cycles → `press_pulse[0]` 1 cycle after rise, `release_pulse[0]` 1 cycle after fall, no long/repeat pulses, `held[0]`=0 throughout.
- **Long press with repeat**: ch0 high for 40 cycles → `long_press_pulse[0]` 9–12 cycles after the press pulse, `held[0]`=1 from then on, `repeat_pulse[0]` every 8 cycles, single `release_pulse[0]` at the end.
- **Release wins**: fall coinciding with the third tick → `release_pulse` only, no `long_press_pulse`, state returns to IDLE.
- **Channel independence**: ch0 and ch1 pressed 3 cycles apart → independent pulses with no cross-talk.
- **Reset mid-hold**: `rst` pulsed for 2 cycles while ch0 is HELD and input stays high → all outputs 0 during reset, then `press_pulse[0]` 1 cycle after `rst` falls and the long-press timing restarts.
- **Repeat compiled out**: `BUTTON_REPEAT_EN` undefined, ch0 held 40 cycles → `long_press_pulse` once, `repeat_pulse` never asserted.

Source files
------------

// File: rtl/button_event_gen.sv
// button_event_gen: debounced levels -> press/release/long-press/repeat pulses.
// Auto-repeat is built only when BUTTON_REPEAT_EN is defined.
module button_event_gen #(
  parameter int width            = 1,
  parameter int tick_count_max   = 25000,
  parameter int long_press_ticks = 1000,
  parameter int repeat_ticks     = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] debounced_signal,
  output logic [width-1:0] press_pulse,
  output logic [width-1:0] release_pulse,
  output logic [width-1:0] long_press_pulse,
  output logic [width-1:0] repeat_pulse,
  output logic [width-1:0] held
);

  localparam int TW = $clog2(tick_count_max) + 1;
  localparam int HW = $clog2(long_press_ticks) + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(tick_count_max - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(long_press_ticks - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESSED,
    S_HELD
  } state_t;

  if (tick_count_max < 1 || long_press_ticks < 1 || repeat_ticks < 1)
  begin : g_bad_param
    $error("button_event_gen: timing parameters must be >= 1");
  end

  logic [TW-1:0] r_presc;
  logic          w_tick;

  assign w_tick = (r_presc == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst)         r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + 1'b1;
  end

  for (genvar g = 0; g < width; g++) begin : g_ch
    state_t        r_state, w_state;
    logic          r_prev, w_in;
    logic [HW-1:0] r_hold, w_hold;
    logic          r_press, r_rel, r_long;
    logic          w_press, w_rel, w_long;
`ifdef BUTTON_REPEAT_EN
    localparam int RW = $clog2(repeat_ticks) + 1;
    localparam logic [RW-1:0] REP_LAST = RW'(repeat_ticks - 1);
    logic [RW-1:0] r_rcnt, w_rcnt;
    logic          r_rep, w_rep;
`endif

    assign w_in = debounced_signal[g];

    // Release is checked before the tick so it always wins.
    always_comb begin
      w_state = r_state;
      w_hold  = r_hold;
      w_press = 1'b0;
      w_rel   = 1'b0;
      w_long  = 1'b0;
`ifdef BUTTON_REPEAT_EN
      w_rcnt  = r_rcnt;
      w_rep   = 1'b0;
`endif
      unique case (r_state)
        S_IDLE: begin
          if (w_in && !r_prev) begin
            w_state = S_PRESSED;
            w_hold  = '0;
            w_press = 1'b1;
          end
        end
        S_PRESSED: begin
          if (!w_in) begin
            w_state = S_IDLE;
            w_rel   = 1'b1;
          end else if (w_tick) begin
            if (r_hold == HOLD_LAST) begin
              w_state = S_HELD;
              w_long  = 1'b1;
`ifdef BUTTON_REPEAT_EN
              w_rcnt  = '0;
`endif
            end else begin
              w_hold = r_hold + 1'b1;
            end
          end
        end
        S_HELD: begin
          if (!w_in) begin
            w_state = S_IDLE;
            w_rel   = 1'b1;
          end
`ifdef BUTTON_REPEAT_EN
          else if (w_tick) begin
            if (r_rcnt == REP_LAST) begin
              w_rep  = 1'b1;
              w_rcnt = '0;
            end else begin
              w_rcnt = r_rcnt + 1'b1;
            end
          end
`endif
        end
        default: w_state = S_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= S_IDLE;
        r_prev  <= 1'b0;
        r_hold  <= '0;
        r_press <= 1'b0;
        r_rel   <= 1'b0;
        r_long  <= 1'b0;
`ifdef BUTTON_REPEAT_EN
        r_rcnt  <= '0;
        r_rep   <= 1'b0;
`endif
      end else begin
        r_state <= w_state;
        r_prev  <= w_in;
        r_hold  <= w_hold;
        r_press <= w_press;
        r_rel   <= w_rel;
        r_long  <= w_long;
`ifdef BUTTON_REPEAT_EN
        r_rcnt  <= w_rcnt;
        r_rep   <= w_rep;
`endif
      end
    end

    assign press_pulse[g]      = r_press;
    assign release_pulse[g]    = r_rel;
    assign long_press_pulse[g] = r_long;
    assign held[g]             = (r_state == S_HELD);
`ifdef BUTTON_REPEAT_EN
    assign repeat_pulse[g]     = r_rep;
`else
    assign repeat_pulse[g]     = 1'b0;
`endif
  end

endmodule

// File: tb/tb_button_event_gen.sv
// Bench for button_event_gen: scenario tasks checked against a
// tick-counting reference model; honours BUTTON_REPEAT_EN.
module tb_button_event_gen;

  localparam int W   = 2;
  localparam int TCM = 4;
  localparam int LPT = 3;
  localparam int RPT = 2;
`ifdef BUTTON_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic [W-1:0] pp, rp, lp, rpp, hd;
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  button_event_gen #(
    .width(W),
    .tick_count_max(TCM),
    .long_press_ticks(LPT),
    .repeat_ticks(RPT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .debounced_signal(din),
    .press_pulse(pp),
    .release_pulse(rp),
    .long_press_pulse(lp),
    .repeat_pulse(rpp),
    .held(hd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference model: count ticks seen since the press was accepted.
  // Long press on tick LPT, repeat on every RPT ticks after that.
  int           j = 0;
  int           m_nt [W];
  bit   [W-1:0] m_prev = '0;
  bit   [W-1:0] m_act  = '0;
  logic [W-1:0] e_p = '0, e_r = '0, e_l = '0, e_rp = '0, e_h = '0;

  always @(posedge clk) begin
    bit tk;
    if (rst) begin
      j = 0;
      m_prev = '0;
      m_act = '0;
      for (int c = 0; c < W; c++) m_nt[c] = 0;
      e_p = '0; e_r = '0; e_l = '0; e_rp = '0; e_h = '0;
    end else begin
      tk = ((j % TCM) == TCM - 1);
      j++;
      for (int c = 0; c < W; c++) begin
        e_p[c] = 0; e_r[c] = 0; e_l[c] = 0; e_rp[c] = 0;
        if (!m_act[c]) begin
          if (din[c] && !m_prev[c]) begin
            m_act[c] = 1; m_nt[c] = 0; e_p[c] = 1;
          end
        end else if (!din[c]) begin
          m_act[c] = 0; e_r[c] = 1;
        end else if (tk) begin
          m_nt[c]++;
          if (m_nt[c] == LPT) e_l[c] = 1;
          else if (REP && m_nt[c] > LPT && (m_nt[c] - LPT) % RPT == 0)
            e_rp[c] = 1;
        end
        m_prev[c] = din[c];
        e_h[c] = m_act[c] && (m_nt[c] >= LPT);
      end
    end
  end

  logic [5*W-1:0] dut_v, exp_v;
  assign dut_v = {pp, rp, lp, rpp, hd};
  assign exp_v = {e_p, e_r, e_l, e_rp, e_h};

  task automatic test_reset();
    rst = 1'b1;
    din = '1;
    repeat (3) @(negedge clk);
    total++;
    if (dut_v !== '0) begin
      bad++;
      $display("FAIL reset_outs got=%b want=0", dut_v);
    end
    din = '0;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (dut_v !== exp_v) begin
        bad++;
        $display("FAIL reset_idle c=%0d got=%b want=%b", cyc, dut_v, exp_v);
      end
    end
  endtask

  task automatic test_short_press();
    int tp = -1, tr = -1, td, tf = 0, np = 0, nr = 0, nx = 0;
    din[0] = 1'b1;
    td = cyc;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (dut_v !== exp_v) begin
        bad++;
        $display("FAIL short c=%0d got=%b want=%b", cyc, dut_v, exp_v);
      end
      if (pp[0]) begin tp = cyc; np++; end
      if (rp[0]) begin tr = cyc; nr++; end
      if (lp[0] || rpp[0] || hd[0]) nx++;
      if (i == 4) begin din[0] = 1'b0; tf = cyc; end
    end
    total++;
    if (tp != td + 1 || np != 1) begin
      bad++;
      $display("FAIL short_press t=%0d n=%0d want t=%0d n=1", tp, np, td + 1);
    end
    total++;
    if (tr != tf + 1 || nr != 1) begin
      bad++;
      $display("FAIL short_rel t=%0d n=%0d want t=%0d n=1", tr, nr, tf + 1);
    end
    total++;
    if (nx != 0) begin
      bad++;
      $display("FAIL short_extra got=%0d want=0", nx);
    end
  endtask

  task automatic test_long_press();
    int tp = -1, tl = -1, tr = -1, tprev = -1, td = 0;
    int nl = 0, nr = 0, nrep = 0, ierr = 0, want;
    din[0] = 1'b1;
    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      total++;
      if (dut_v !== exp_v) begin
        bad++;
        $display("FAIL long c=%0d got=%b want=%b", cyc, dut_v, exp_v);
      end
      if (pp[0]) tp = cyc;
      if (rp[0]) begin tr = cyc; nr++; end
      if (lp[0]) begin tl = cyc; tprev = cyc; nl++; end
      if (rpp[0]) begin
        nrep++;
        if (cyc - tprev != RPT * TCM) ierr++;
        tprev = cyc;
      end
      if (i == 39) begin din[0] = 1'b0; td = cyc; end
    end
    total++;
    if (nl != 1 || tl - tp < (LPT - 1) * TCM + 1 || tl - tp > LPT * TCM) begin
      bad++;
      $display("FAIL long_lat n=%0d dt=%0d want n=1 dt in [%0d,%0d]",
               nl, tl - tp, (LPT - 1) * TCM + 1, LPT * TCM);
    end
    want = (REP && tl >= 0) ? (td - tl) / (RPT * TCM) : 0;
    total++;
    if (nrep != want || ierr != 0) begin
      bad++;
      $display("FAIL long_rep n=%0d ierr=%0d want n=%0d ierr=0",
               nrep, ierr, want);
    end
    total++;
    if (nr != 1 || tr != td + 1) begin
      bad++;
      $display("FAIL long_rel n=%0d t=%0d want n=1 t=%0d", nr, tr, td + 1);
    end
  endtask

  task automatic test_release_wins();
    int nl = 0, nr = 0, nh = 0;
    bit hit = 0;
    repeat (2) @(negedge clk);
    din[0] = 1'b1;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      total++;
      if (dut_v !== exp_v) begin
        bad++;
        $display("FAIL relwin c=%0d got=%b want=%b", cyc, dut_v, exp_v);
      end
      if (m_act[0] && m_nt[0] == LPT - 1 && (j % TCM) == TCM - 1) hit = 1;
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL relwin_sync got=timeout want=aligned");
    end
    din[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (dut_v !== exp_v) begin
        bad++;
        $display("FAIL relwin c=%0d got=%b want=%b", cyc, dut_v, exp_v);
      end
      if (lp[0]) nl++;
      if (rp[0]) nr++;
      if (hd[0]) nh++;
    end
    total++;
    if (nl != 0 || nr != 1 || nh != 0) begin
      bad++;
      $display("FAIL relwin_out long=%0d rel=%0d held=%0d want 0/1/0",
               nl, nr, nh);
    end
  endtask

  task automatic test_channels();
    int h0, h1;
    int tp0 = -1, tp1 = -1, np0 = 0, np1 = 0, nr0 = 0, nr1 = 0;
    h0 = $urandom_range(3, 30);
    h1 = $urandom_range(3, 30);
    din = 2'b01;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      total++;
      if (dut_v !== exp_v) begin
        bad++;
        $display("FAIL chan c=%0d got=%b want=%b", cyc, dut_v, exp_v);
      end
      if (pp[0]) begin tp0 = cyc; np0++; end
      if (pp[1]) begin tp1 = cyc; np1++; end
      if (rp[0]) nr0++;
      if (rp[1]) nr1++;
      din[0] = (i + 1 < h0);
      din[1] = (i + 1 >= 3 && i + 1 < 3 + h1);
    end
    total++;
    if (tp1 - tp0 != 3 || np0 != 1 || np1 != 1 || nr0 != 1 || nr1 != 1) begin
      bad++;
      $display("FAIL chan_pair dt=%0d p=%0d/%0d r=%0d/%0d want dt=3 all 1",
               tp1 - tp0, np0, np1, nr0, nr1);
    end
  endtask

  task automatic test_reset_mid_hold();
    int tp = -1, tl = -1, nr = 0, cr;
    bit up = 0;
    din = 2'b01;
    for (int i = 0; i < 30 && !up; i++) begin
      @(negedge clk);
      if (hd[0]) up = 1;
    end
    total++;
    if (!up) begin
      bad++;
      $display("FAIL rstmid_held got=0 want=1");
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (dut_v !== '0) begin
        bad++;
        $display("FAIL rstmid_outs got=%b want=0", dut_v);
      end
    end
    rst = 1'b0;
    cr = cyc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (dut_v !== exp_v) begin
        bad++;
        $display("FAIL rstmid c=%0d got=%b want=%b", cyc, dut_v, exp_v);
      end
      if (pp[0] && tp < 0) tp = cyc;
      if (lp[0] && tl < 0) tl = cyc;
      if (rp[0]) nr++;
    end
    total++;
    if (tp != cr + 1 || nr != 0) begin
      bad++;
      $display("FAIL rstmid_press t=%0d rel=%0d want t=%0d rel=0",
               tp, nr, cr + 1);
    end
    total++;
    if (tl - tp < (LPT - 1) * TCM + 1 || tl - tp > LPT * TCM) begin
      bad++;
      $display("FAIL rstmid_long dt=%0d want [%0d,%0d]",
               tl - tp, (LPT - 1) * TCM + 1, LPT * TCM);
    end
    din = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      total++;
      if (dut_v !== exp_v) begin
        bad++;
        $display("FAIL random c=%0d got=%b want=%b", cyc, dut_v, exp_v);
      end
      for (int c = 0; c < W; c++)
        if ($urandom_range(0, 11) == 0) din[c] = ~din[c];
      rst = ($urandom_range(0, 199) == 0);
    end
    rst = 1'b0;
    din = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_short_press();
    repeat (3) @(negedge clk);
    test_long_press();
    repeat (3) @(negedge clk);
    test_release_wins();
    test_channels();
    test_reset_mid_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
